// File: rtl/rsa_pkg.sv
// rsa_pkg: shared RSA constants and Montgomery multiplier state encoding
package rsa_pkg;
    localparam int RSA_WIDTH = 256;
    localparam int CNT_W = 9;
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_SUB} mont_state_t;
endpackage

// File: rtl/rsa_mont_mul_if.sv
// rsa_mont_mul_if: request/response bundle of the Montgomery multiplier
//   i_start        request strobe, sampled while idle
//   i_a, i_b, i_n  multiplicand, multiplier, odd modulus
//   o_result       A*B*2^-WIDTH mod N, held until the next accepted request
//   o_done         single-cycle completion pulse
//   o_busy         high while a request is in flight
interface rsa_mont_mul_if import rsa_pkg::*; #(parameter int WIDTH = RSA_WIDTH);
    logic             i_start;
    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] i_b;
    logic [WIDTH-1:0] i_n;
    logic [WIDTH-1:0] o_result;
    logic             o_done;
    logic             o_busy;
    modport master (output i_start, i_a, i_b, i_n, input o_result, o_done, o_busy);
    modport slave  (input i_start, i_a, i_b, i_n, output o_result, o_done, o_busy);
endinterface

// File: rtl/rsa_mont_step.sv
// rsa_mont_step: one radix-2 Montgomery iteration, m' = (m + a_bit*b [+ n]) / 2
//   i_m      running accumulator (WIDTH+2 bits, stays below 2N)
//   i_b      latched multiplier
//   i_n      latched modulus
//   i_a_bit  current multiplicand bit
//   o_m      next accumulator
module rsa_mont_step #(parameter int WIDTH = 256) (
    input  logic [WIDTH+1:0] i_m,
    input  logic [WIDTH-1:0] i_b,
    input  logic [WIDTH-1:0] i_n,
    input  logic             i_a_bit,
    output logic [WIDTH+1:0] o_m
);
    // one spare bit above WIDTH+2 so m + b + n never wraps, even out of contract
    logic [WIDTH+2:0] w_t0;
    logic [WIDTH+2:0] w_t1;
    always_comb begin
        w_t0 = {1'b0, i_m} + (i_a_bit ? {3'b0, i_b} : '0);
        w_t1 = w_t0[0] ? w_t0 + {3'b0, i_n} : w_t0;
        o_m  = w_t1[WIDTH+2:1];
    end
endmodule

// File: rtl/rsa_mont_mul.sv
// rsa_mont_mul: iterative radix-2 Montgomery multiplier, fixed 257-cycle latency
//   i_clk, i_rst  clock and asynchronous active-high reset
//   bus           slave side of rsa_mont_mul_if (start/operands in, result/done/busy out)
module rsa_mont_mul import rsa_pkg::*; #(
    parameter int WIDTH = RSA_WIDTH,
    parameter int CNT_W = rsa_pkg::CNT_W
) (
    input logic           i_clk,
    input logic           i_rst,
    rsa_mont_mul_if.slave bus
);
    mont_state_t      r_state;
    mont_state_t      w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH+1:0] r_m;
    logic [WIDTH+1:0] w_m_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_n;
    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] w_result;
    logic             r_done;
    logic             w_last;

    rsa_mont_step #(.WIDTH(WIDTH)) u_step (
        .i_m    (r_m),
        .i_b    (r_b),
        .i_n    (r_n),
        .i_a_bit(r_a[0]),
        .o_m    (w_m_next)
    );

    always_comb begin
        w_last   = r_cnt == CNT_W'(WIDTH - 1);
        w_next   = r_state == S_IDLE ? (bus.i_start ? S_CALC : S_IDLE) :
                   r_state == S_CALC ? (w_last ? S_SUB : S_CALC) : S_IDLE;
        w_result = r_m >= {2'b0, r_n} ? WIDTH'(r_m - {2'b0, r_n}) : WIDTH'(r_m);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // multiplicand is shifted right each step so bit i is always at r_a[0]
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt    <= '0;
            r_m      <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_n      <= '0;
            r_result <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= r_state == S_SUB;
            if (r_state == S_IDLE && bus.i_start) begin
                r_a   <= bus.i_a;
                r_b   <= bus.i_b;
                r_n   <= bus.i_n;
                r_m   <= '0;
                r_cnt <= '0;
            end
            if (r_state == S_CALC) begin
                r_m   <= w_m_next;
                r_a   <= r_a >> 1;
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (r_state == S_SUB) r_result <= w_result;
        end
    end

    assign bus.o_result = r_result;
    assign bus.o_done   = r_done;
    assign bus.o_busy   = r_state != S_IDLE;
endmodule

// File: tb/tb_rsa_mont_mul.sv
// tb_rsa_mont_mul: randomized self-checking bench against a REDC bignum reference
module tb_rsa_mont_mul;
    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    rsa_mont_mul_if bus();

    rsa_mont_mul dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // A*B*R^-1 mod N via word-level REDC: k = -AB * N^-1 mod R, (AB + kN) / R
    function automatic logic [255:0] mont_ref(input logic [255:0] a, input logic [255:0] b, input logic [255:0] n);
        logic [511:0] p;
        logic [255:0] inv;
        logic [255:0] k;
        logic [513:0] s;
        logic [257:0] t;
        p = {256'd0, a} * {256'd0, b};
        inv = n;
        for (int i = 0; i < 8; i++) inv = inv * (256'd2 - n * inv);
        k = (256'd0 - p[255:0]) * inv;
        s = {2'b0, p} + 514'(k) * 514'(n);
        t = s[513:256];
        if (t >= {2'b0, n}) t = t - {2'b0, n};
        return t[255:0];
    endfunction

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // issue one request and wait for done; l counts edges after the accepting edge
    task automatic run_req(input logic [255:0] a, input logic [255:0] b, input logic [255:0] n,
                           output logic [255:0] res, output int l);
        @(negedge clk);
        bus.i_a = a;
        bus.i_b = b;
        bus.i_n = n;
        bus.i_start = 1'b1;
        @(negedge clk);
        bus.i_start = 1'b0;
        bus.i_a = ~a;
        bus.i_b = ~b;
        bus.i_n = ~n;
        l = 0;
        while (!bus.o_done && l < 400) begin
            @(negedge clk);
            l++;
        end
        res = bus.o_result;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.i_start = 1'b0;
        bus.i_a = '0;
        bus.i_b = '0;
        bus.i_n = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        checks++;
        if (bus.o_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", bus.o_done); end
        checks++;
        if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.o_busy); end
        checks++;
        if (bus.o_result !== '0) begin errors++; $display("FAIL reset_result got=%h exp=0", bus.o_result); end
    endtask

    task automatic test_small();
        logic [255:0] r;
        int l;
        run_req(256'd1, 256'd3, 256'd13, r, l);
        checks++;
        if (r !== 256'd1) begin errors++; $display("FAIL small_result got=%0d exp=1", r); end
        checks++;
        if (l != 257) begin errors++; $display("FAIL small_latency got=%0d exp=257", l); end
    endtask

    task automatic test_identity();
        logic [255:0] r;
        int l;
        logic [255:0] va[3] = '{256'd3, 256'd12, 256'd0};
        logic [255:0] vb[3] = '{256'd7, 256'd12, 256'd12};
        logic [255:0] ve[3] = '{256'd7, 256'd9, 256'd0};
        for (int i = 0; i < 3; i++) begin
            run_req(va[i], vb[i], 256'd13, r, l);
            checks++;
            if (r !== ve[i]) begin errors++; $display("FAIL identity_%0d got=%0d exp=%0d", i, r, ve[i]); end
        end
    endtask

    task automatic test_full_width();
        logic [255:0] n;
        logic [255:0] r;
        logic [255:0] e;
        int l;
        n = 256'd0 - 256'd189;
        e = mont_ref(n - 1, n - 1, n);
        run_req(n - 1, n - 1, n, r, l);
        checks++;
        if (r !== e) begin errors++; $display("FAIL full_max got=%h exp=%h", r, e); end
    endtask

    task automatic test_random();
        logic [255:0] n;
        logic [255:0] a;
        logic [255:0] b;
        logic [255:0] r;
        logic [255:0] e;
        int l;
        for (int i = 0; i < 150; i++) begin
            n = rnd256() | 256'd1;
            if (i % 2 == 0) n[255] = 1'b1;
            if (n == 256'd1) n = 256'd3;
            a = rnd256() % n;
            b = rnd256() % n;
            e = mont_ref(a, b, n);
            run_req(a, b, n, r, l);
            checks++;
            if (r !== e) begin errors++; $display("FAIL random_%0d got=%h exp=%h", i, r, e); end
            checks++;
            if (l != 257) begin errors++; $display("FAIL random_lat_%0d got=%0d exp=257", i, l); end
        end
    endtask

    task automatic test_start_ignored();
        logic [255:0] n;
        logic [255:0] a;
        logic [255:0] b;
        logic [255:0] e;
        int l;
        int extra;
        n = rnd256() | 256'd1;
        a = rnd256() % n;
        b = rnd256() % n;
        e = mont_ref(a, b, n);
        @(negedge clk);
        bus.i_a = a;
        bus.i_b = b;
        bus.i_n = n;
        bus.i_start = 1'b1;
        @(negedge clk);
        bus.i_start = 1'b0;
        l = 0;
        while (!bus.o_done && l < 400) begin
            @(negedge clk);
            l++;
            bus.i_start = l == 95;
            if (l == 95) begin
                bus.i_a = 256'd1;
                bus.i_b = 256'd3;
                bus.i_n = 256'd13;
            end
        end
        checks++;
        if (bus.o_result !== e) begin errors++; $display("FAIL ignore_result got=%h exp=%h", bus.o_result, e); end
        checks++;
        if (l != 257) begin errors++; $display("FAIL ignore_latency got=%0d exp=257", l); end
        extra = 0;
        repeat (300) begin
            @(negedge clk);
            if (bus.o_done || bus.o_busy) extra++;
        end
        checks++;
        if (extra != 0) begin errors++; $display("FAIL ignore_no_second got=%0d exp=0", extra); end
    endtask

    task automatic test_back_to_back();
        logic [255:0] n;
        logic [255:0] a;
        logic [255:0] b;
        logic [255:0] e1;
        logic [255:0] e2;
        logic [255:0] r;
        int l;
        int c;
        n = rnd256() | 256'd1;
        a = rnd256() % n;
        b = rnd256() % n;
        e1 = mont_ref(a, b, n);
        e2 = mont_ref(b, b, n);
        run_req(a, b, n, r, l);
        checks++;
        if (r !== e1) begin errors++; $display("FAIL b2b_first got=%h exp=%h", r, e1); end
        bus.i_a = b;
        bus.i_b = b;
        bus.i_n = n;
        bus.i_start = 1'b1;
        @(negedge clk);
        bus.i_start = 1'b0;
        checks++;
        if (bus.o_done !== 1'b0) begin errors++; $display("FAIL b2b_pulse_width got=%b exp=0", bus.o_done); end
        c = 1;
        while (!bus.o_done && c < 400) begin
            @(negedge clk);
            c++;
        end
        checks++;
        if (c != 258) begin errors++; $display("FAIL b2b_spacing got=%0d exp=258", c); end
        checks++;
        if (bus.o_result !== e2) begin errors++; $display("FAIL b2b_second got=%h exp=%h", bus.o_result, e2); end
    endtask

    task automatic test_reset_mid();
        logic [255:0] r;
        int l;
        int fired;
        @(negedge clk);
        bus.i_a = 256'd5;
        bus.i_b = 256'd7;
        bus.i_n = 256'd13;
        bus.i_start = 1'b1;
        @(negedge clk);
        bus.i_start = 1'b0;
        repeat (119) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b exp=0", bus.o_busy); end
        checks++;
        if (bus.o_result !== '0) begin errors++; $display("FAIL midrst_result got=%h exp=0", bus.o_result); end
        @(negedge clk);
        rst = 1'b0;
        fired = 0;
        repeat (300) begin
            @(negedge clk);
            if (bus.o_done) fired++;
        end
        checks++;
        if (fired != 0) begin errors++; $display("FAIL midrst_no_done got=%0d exp=0", fired); end
        run_req(256'd1, 256'd3, 256'd13, r, l);
        checks++;
        if (r !== 256'd1) begin errors++; $display("FAIL midrst_after got=%0d exp=1", r); end
        checks++;
        if (l != 257) begin errors++; $display("FAIL midrst_latency got=%0d exp=257", l); end
    endtask

    initial begin
        test_reset();
        test_small();
        test_identity();
        test_full_width();
        test_random();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
